mac_sequencer: RTL

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_pkg.sv | 14 +
 rtl/adder_module.sv | 15 +
 rtl/mac_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer.
// Holds the FSM state enumeration, the operand width and the MUL iteration count.
package mac_pkg;
  localparam int OP_W   = 8;
  localparam int ITER_N = 8;
  localparam int CNT_W  = $clog2(ITER_N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/adder_module.sv
// Adder_Module: W-bit unsigned adder with a carry-out bit.
// Ports:
//   en  - enable; the sum reads 0 while low
//   a,b - W-bit unsigned addends
//   sum - W+1-bit result {carry, sum}
module Adder_Module #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);
  assign sum = en ? ({1'b0, a} + {1'b0, b}) : '0;
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: 8x8 unsigned shift-add multiplier feeding an ACC_W-bit accumulator.
// One multiply-accumulate takes 8 MUL cycles, 1 ACC cycle and 1 DONE cycle.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - begin a MAC (accepted in IDLE only)
//   clr_acc       - with start: replace acc with the product; alone in IDLE: clear acc/ovf
//   a, b          - 8-bit unsigned operands, sampled when start is accepted
//   busy, done    - busy in MUL/ACC, done is a one-cycle pulse
//   product       - last completed a*b
//   acc, ovf      - running accumulator and sticky overflow flag
// Build option: define MAC_SAT_EN to saturate acc on overflow instead of wrapping.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_acc,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             busy,
  output logic             done,
  output logic [15:0]      product,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   hi, lo, a_r;
  logic              clr_r;
  logic              mul_en;
  logic [OP_W:0]     add_sum, step_sum;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W:0]    acc_sum;

  assign mul_en = (state == S_MUL);

  Adder_Module #(.W(OP_W)) u_add (
    .en  (mul_en),
    .a   (hi),
    .b   (a_r),
    .sum (add_sum)
  );

  // lo[0] selects whether this step adds the multiplicand into the high half
  assign step_sum = lo[0] ? add_sum : {1'b0, hi};

  // A captured clear makes the product replace acc rather than add to it
  assign acc_base = clr_r ? '0 : acc;
  assign acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - 2*OP_W){1'b0}}, hi, lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_MUL;
      S_MUL: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_ACC;
      end
      S_ACC: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      a_r     <= '0;
      clr_r   <= 1'b0;
      product <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            lo    <= b;
            hi    <= '0;
            clr_r <= clr_acc;
            cnt   <= CNT_W'(ITER_N - 1);
          end else if (clr_acc) begin
            acc <= '0;
            ovf <= 1'b0;
          end
        end
        S_MUL: begin
          // {hi, lo} <= {sum, lo} >> 1; the carry lands in hi[7]
          hi <= step_sum[OP_W:1];
          lo <= {step_sum[0], lo[OP_W-1:1]};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_ACC: begin
          product <= {hi, lo};
`ifdef MAC_SAT_EN
          acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
          acc <= acc_sum[ACC_W-1:0];
`endif
          // A captured clear drops the old sticky flag before this add is judged
          ovf <= (clr_r ? 1'b0 : ovf) | acc_sum[ACC_W];
        end
        default: ;
      endcase
    end
  end

endmodule
